dmem_write_buffer: RTL

Store buffer between the processor's memory-stage dmem port and a simple dual-port data RAM (one write port, one synchronous read port). Stores are queued in a small FIFO and drained to the RAM one per cycle, decoupling the memory stage from RAM write timing. Loads read the RAM directly. Any load whose address matches a queued store returns the youngest buffered data, so the buffer is invisible to software.

---
 rtl/dmem_write_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_write_buffer.sv
// Store buffer between the memory-stage dmem port and a 1W/1R synchronous RAM.
// Stores drain in FIFO order, one per cycle; loads forward from the youngest matching entry.
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              cpu_addr,
  input  logic [DATA_W-1:0]        cpu_data,
  input  logic                     cpu_wren,
  output logic [DATA_W-1:0]        cpu_q,
  output logic                     cpu_stall,
  output logic [ADDR_W-1:0]        ram_raddr,
  input  logic [DATA_W-1:0]        ram_q,
  output logic [ADDR_W-1:0]        ram_waddr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_wren,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [ADDR_W-1:0] cpu_word;
  logic              push, pop;
  logic [DEPTH-1:0]  match;
  logic              sel_hit;
  logic [DATA_W-1:0] sel_data;
  logic              unused_addr_hi;

  assign cpu_word       = cpu_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^cpu_addr[31:ADDR_W];

  // Stall is decided on the registered count only, so a same-cycle pop never frees a slot.
  assign cpu_stall = cpu_wren & (count_q == FULL);
  assign push      = cpu_wren & (count_q != FULL);
  assign pop       = (count_q != '0);

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ram_wren  = pop;
  assign ram_waddr = addr_q[head_q];
  assign ram_wdata = data_q[head_q];
  assign ram_raddr = cpu_word;
  assign cpu_q     = fwd_hit_q ? fwd_data_q : ram_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - head_q;
      assign match[gi] = ({1'b0, age} < count_q) && (addr_q[gi] == cpu_word);

      always_ff @(posedge clock) begin
        if (push && (tail_q == PTR_W'(gi))) begin
          addr_q[gi] <= cpu_word;
          data_q[gi] <= cpu_data;
        end
      end
    end
  endgenerate

  // Walk from head toward tail so the last match seen is the youngest store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    sel_hit  = 1'b0;
    sel_data = '0;
    idx      = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (match[idx]) begin
        sel_hit  = 1'b1;
        sel_data = data_q[idx];
      end
    end
  end

  always_comb begin
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q;
    fwd_hit_d  = ~cpu_wren & sel_hit;
    fwd_data_d = cpu_wren ? fwd_data_q : sel_data;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule
